// File: rtl/mem_preloader_pkg.sv
// Shared types and helpers for the boot-time memory preloader.
// The optional clear phase is selected with the MEM_PRELOADER_CLEAR_EN macro.
package mem_preloader_pkg;

  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_CLEAR,
    ST_LOAD_WAIT,
    ST_LOAD_WR,
    ST_DONE,
    ST_ERROR
  } state_e;

  function automatic int unsigned BYTES_PER_WORD(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/mem_preloader_wb_wr.sv
// Single classic Wishbone write engine: one write per start, cyc/stb/we drop
// for at least one cycle after every termination. Termination pulses are combinational.
module mem_preloader_wb_wr
  import mem_preloader_pkg::*;
#(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   AW      = 32,
  parameter logic [AW-1:0] RST_ADR = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [AW-1:0]                 adr_i,
  input  logic [DW-1:0]                 dat_i,
  output logic                          busy_o,
  output logic                          ack_c_o,
  output logic                          err_c_o,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [AW-1:0]                 wb_adr_o,
  output logic [DW-1:0]                 wb_dat_o,
  output logic [BYTES_PER_WORD(DW)-1:0] wb_sel_o,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i
);

  logic          cyc_q, cyc_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;

  // A start is only taken while idle, so a new cycle always follows an idle cycle.
  always_comb begin
    cyc_d = cyc_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (cyc_q) begin
      if (wb_ack_i || wb_err_i) cyc_d = 1'b0;
    end else if (start_i) begin
      cyc_d = 1'b1;
      adr_d = adr_i;
      dat_d = dat_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cyc_q <= 1'b0;
      adr_q <= RST_ADR;
      dat_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  // Slave terminations are only meaningful inside a cycle; err wins over ack.
  assign ack_c_o  = cyc_q & wb_ack_i & ~wb_err_i;
  assign err_c_o  = cyc_q & wb_err_i;
  assign busy_o   = cyc_q;
  assign wb_cyc_o = cyc_q;
  assign wb_stb_o = cyc_q;
  assign wb_we_o  = cyc_q;
  assign wb_adr_o = adr_q;
  assign wb_dat_o = dat_q;
  assign wb_sel_o = '1;

endmodule

// File: rtl/wb_mem_preloader.sv
// Boot preloader: holds the CPU in reset, optionally clears RAM, streams the image
// into RAM over Wishbone, then releases the CPU. Clear phase: MEM_PRELOADER_CLEAR_EN.
module wb_mem_preloader
  import mem_preloader_pkg::*;
#(
  parameter int unsigned     DW        = 32,
  parameter int unsigned     AW        = 32,
  parameter longint unsigned MEM_SIZE  = 64'h0200_0000,
  parameter longint unsigned BASE_ADDR = 64'h0,
  parameter int unsigned     RST_HOLD  = 16,
  parameter logic [DW-1:0]   FILL      = '0
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          load_en_i,
  input  logic                          load_valid_i,
  output logic                          load_ready_o,
  input  logic [DW-1:0]                 load_data_i,
  input  logic                          load_last_i,
  output logic                          wb_cyc_o,
  output logic                          wb_stb_o,
  output logic                          wb_we_o,
  output logic [AW-1:0]                 wb_adr_o,
  output logic [DW-1:0]                 wb_dat_o,
  output logic [BYTES_PER_WORD(DW)-1:0] wb_sel_o,
  input  logic                          wb_ack_i,
  input  logic                          wb_err_i,
  output logic                          cpu_rst_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [AW-1:0]                 words_o
);

  localparam int unsigned             BPW       = BYTES_PER_WORD(DW);
  localparam logic [AW-1:0]           BASE_A    = AW'(BASE_ADDR);
  localparam logic [AW-1:0]           STEP      = AW'(BPW);
  localparam logic [AW-1:0]           MEM_A     = AW'(MEM_SIZE);
  localparam logic [HOLD_CNT_W-1:0]   HOLD_LAST = HOLD_CNT_W'(RST_HOLD - 1);

  if (!(DW == 32 || DW == 64)) begin : g_bad_dw
    $error("wb_mem_preloader: DW must be 32 or 64");
  end
  if ((MEM_SIZE % BPW) != 0 || MEM_SIZE == 0) begin : g_bad_mem
    $error("wb_mem_preloader: MEM_SIZE must be a non-zero multiple of DW/8");
  end
  if (RST_HOLD < 1 || RST_HOLD > 255) begin : g_bad_hold
    $error("wb_mem_preloader: RST_HOLD must be in 1..255");
  end
  if (AW < 64) begin : g_chk_span
    if ((BASE_ADDR + MEM_SIZE) > (64'd1 << AW)) begin : g_bad_span
      $error("wb_mem_preloader: BASE_ADDR+MEM_SIZE exceeds the address space");
    end
  end

  state_e                  state_q, state_d;
  logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [AW-1:0]           words_q, words_d;
  logic [AW-1:0]           off_q, off_d;
  logic                    last_q, last_d;
  logic                    first_q, first_d;
  logic                    cpu_rst_q, cpu_rst_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
`ifdef MEM_PRELOADER_CLEAR_EN
  localparam logic [AW-1:0] LAST_OFF = AW'(MEM_SIZE - longint'(BPW));
  logic [AW-1:0]           clr_off_q, clr_off_d;
`endif

  logic                    load_ready_c;
  logic                    wr_start, wr_busy, wr_ack, wr_err;
  logic [AW-1:0]           wr_adr;
  logic [DW-1:0]           wr_dat;

  // Next-state, counters and write requests.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    words_d      = words_q;
    off_d        = off_q;
    last_d       = last_q;
    first_d      = first_q;
    load_ready_c = 1'b0;
    wr_start     = 1'b0;
    wr_adr       = BASE_A + off_q;
    wr_dat       = FILL;
`ifdef MEM_PRELOADER_CLEAR_EN
    clr_off_d    = clr_off_q;
`endif
    case (state_q)
      ST_HOLD: begin
        hold_cnt_d = hold_cnt_q + HOLD_CNT_W'(1);
        if (hold_cnt_q == HOLD_LAST) begin
`ifdef MEM_PRELOADER_CLEAR_EN
          state_d = ST_CLEAR;
`else
          state_d = ST_LOAD_WAIT;
`endif
        end
      end
`ifdef MEM_PRELOADER_CLEAR_EN
      ST_CLEAR: begin
        wr_adr   = BASE_A + clr_off_q;
        wr_start = ~wr_busy;
        if (wr_err) begin
          state_d = ST_ERROR;
        end else if (wr_ack) begin
          if (clr_off_q == LAST_OFF) state_d = ST_LOAD_WAIT;
          else                       clr_off_d = clr_off_q + STEP;
        end
      end
`endif
      ST_LOAD_WAIT: begin
        // load_en_i only matters on the first cycle of the load phase.
        first_d = 1'b0;
        if (first_q && !load_en_i) begin
          state_d = ST_DONE;
        end else if (!wr_busy) begin
          load_ready_c = 1'b1;
          if (load_valid_i) begin
            if (off_q == MEM_A) begin
              state_d = ST_ERROR;
            end else begin
              last_d   = load_last_i;
              wr_start = 1'b1;
              wr_dat   = load_data_i;
              state_d  = ST_LOAD_WR;
            end
          end
        end
      end
      ST_LOAD_WR: begin
        if (wr_err) begin
          state_d = ST_ERROR;
        end else if (wr_ack) begin
          words_d = words_q + AW'(1);
          off_d   = off_q + STEP;
          state_d = last_q ? ST_DONE : ST_LOAD_WAIT;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
    done_d    = (state_d == ST_DONE);
    err_d     = (state_d == ST_ERROR);
    cpu_rst_d = ~done_d;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      words_q    <= '0;
      off_q      <= '0;
      last_q     <= 1'b0;
      first_q    <= 1'b1;
      cpu_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef MEM_PRELOADER_CLEAR_EN
      clr_off_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      words_q    <= words_d;
      off_q      <= off_d;
      last_q     <= last_d;
      first_q    <= first_d;
      cpu_rst_q  <= cpu_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef MEM_PRELOADER_CLEAR_EN
      clr_off_q  <= clr_off_d;
`endif
    end
  end

  mem_preloader_wb_wr #(
    .DW      (DW),
    .AW      (AW),
    .RST_ADR (BASE_A)
  ) u_wr (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .start_i  (wr_start),
    .adr_i    (wr_adr),
    .dat_i    (wr_dat),
    .busy_o   (wr_busy),
    .ack_c_o  (wr_ack),
    .err_c_o  (wr_err),
    .wb_cyc_o (wb_cyc_o),
    .wb_stb_o (wb_stb_o),
    .wb_we_o  (wb_we_o),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_ack_i (wb_ack_i),
    .wb_err_i (wb_err_i)
  );

  assign load_ready_o = load_ready_c;
  assign cpu_rst_o    = cpu_rst_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign words_o      = words_q;

endmodule

// File: tb/tb_wb_mem_preloader.sv
// Directed bench for wb_mem_preloader: DW=32, MEM_SIZE=64, BASE_ADDR=0x100, RST_HOLD=4,
// zero-wait slave. Clear checks follow MEM_PRELOADER_CLEAR_EN.
module tb_wb_mem_preloader;

`ifdef MEM_PRELOADER_CLEAR_EN
  localparam int CLR_N = 16;
`else
  localparam int CLR_N = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_ack, wb_err;
  logic        cpu_rst, done, err;
  logic [31:0] words;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave knobs: error on write number err_at, optionally with ack; spurious pulses.
  logic err_en = 1'b0, both_mode = 1'b0, spur = 1'b0;
  int   err_at = 0;
  int   wr_idx;
  int   log_n;
  logic [31:0] log_adr [0:63];
  logic [31:0] log_dat [0:63];
  logic err_hit;

  always #5 clk = ~clk;

  assign err_hit = err_en && (wr_idx == err_at);
  assign wb_err  = (wb_cyc & wb_stb & err_hit) | spur;
  assign wb_ack  = (wb_cyc & wb_stb & (~err_hit | both_mode)) | spur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx <= 0;
      log_n  <= 0;
    end else if (wb_cyc && wb_stb && (wb_ack || wb_err)) begin
      wr_idx <= wr_idx + 1;
      if (wb_ack && !wb_err && log_n < 64) begin
        log_adr[log_n] <= wb_adr;
        log_dat[log_n] <= wb_dat;
        log_n <= log_n + 1;
      end
    end
  end

  wb_mem_preloader #(
    .DW(32), .AW(32), .MEM_SIZE(64'd64), .BASE_ADDR(64'h100), .RST_HOLD(4), .FILL(32'hDEADBEEF)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .load_en_i(load_en), .load_valid_i(load_valid), .load_ready_o(load_ready),
    .load_data_i(load_data), .load_last_i(load_last),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat), .wb_sel_o(wb_sel), .wb_ack_i(wb_ack), .wb_err_i(wb_err),
    .cpu_rst_o(cpu_rst), .done_o(done), .err_o(err), .words_o(words)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input logic en);
    rst = 1'b1;
    load_valid = 1'b0;
    load_last = 1'b0;
    load_data = '0;
    load_en = en;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string name, output int waited);
    waited = 0;
    while (load_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    n_tests++;
    if (load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_ready: load_ready_o=%b, required 1 within 200 cycles", name, load_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l);
    logic hs = 1'b0;
    load_valid = 1'b1;
    load_data = d;
    load_last = l;
    for (int i = 0; i < 50 && !hs; i++) begin
      hs = load_ready;
      tick();
    end
    load_valid = 1'b0;
    load_last = 1'b0;
    n_tests++;
    if (!hs) begin
      n_fail++;
      $display("FAIL send_%h: no handshake, required one within 50 cycles", d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({cpu_rst, done, err, wb_cyc, wb_stb, wb_we, load_ready} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_ctl: {rst,done,err,cyc,stb,we,rdy}=%b required 1000000",
               {cpu_rst, done, err, wb_cyc, wb_stb, wb_we, load_ready});
    end
    n_tests++;
    if (words !== 32'd0) begin
      n_fail++; $display("FAIL reset_words: %0d required 0", words);
    end
    n_tests++;
    if (wb_adr !== 32'h100) begin
      n_fail++; $display("FAIL reset_adr: %h required 00000100", wb_adr);
    end
    n_tests++;
    if (wb_dat !== 32'h0) begin
      n_fail++; $display("FAIL reset_dat: %h required 00000000", wb_dat);
    end
  endtask

  task automatic test_hold();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++;
      if (wb_stb !== 1'b0 || cpu_rst !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_c%0d: stb=%b cpu_rst=%b required stb=0 cpu_rst=1", k, wb_stb, cpu_rst);
      end
    end
  endtask

  task automatic test_clear();
    int waited;
    wait_ready("clear", waited);
    n_tests++;
    if (waited != 2 * CLR_N) begin
      n_fail++; $display("FAIL clear_time: ready after %0d cycles required %0d", waited, 2 * CLR_N);
    end
    n_tests++;
    if (log_n != CLR_N) begin
      n_fail++; $display("FAIL clear_count: %0d writes required %0d", log_n, CLR_N);
    end
    for (int i = 0; i < CLR_N; i++) begin
      n_tests++;
      if (log_adr[i] !== 32'h100 + 32'(4 * i) || log_dat[i] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL clear_w%0d: adr=%h dat=%h required adr=%h dat=deadbeef",
                 i, log_adr[i], log_dat[i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_load();
    spur = 1'b1;
    tick();
    tick();
    spur = 1'b0;
    n_tests++;
    if (err !== 1'b0 || load_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_ack_ignored: err=%b rdy=%b required err=0 rdy=1", err, load_ready);
    end
    send_word(32'h11, 1'b0);
    n_tests++;
    if ({wb_cyc, wb_stb, wb_we, wb_sel} !== 7'b1111111 || wb_adr !== 32'h100 || wb_dat !== 32'h11) begin
      n_fail++;
      $display("FAIL load_latency: cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h required 1 1 1 f 00000100 00000011",
               wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat);
    end
    send_word(32'h22, 1'b0);
    tick();
    tick();
    send_word(32'h33, 1'b1);
    n_tests++;
    if (wb_stb !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      n_fail++; $display("FAIL load_ack_cycle: stb=%b done=%b cpu_rst=%b required 1 0 1", wb_stb, done, cpu_rst);
    end
    tick();
    n_tests++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || words !== 32'd3) begin
      n_fail++; $display("FAIL load_done: done=%b cpu_rst=%b words=%0d required 1 0 3", done, cpu_rst, words);
    end
    n_tests++;
    if (log_n != CLR_N + 3 ||
        log_adr[CLR_N] !== 32'h100 || log_dat[CLR_N] !== 32'h11 ||
        log_adr[CLR_N+1] !== 32'h104 || log_dat[CLR_N+1] !== 32'h22 ||
        log_adr[CLR_N+2] !== 32'h108 || log_dat[CLR_N+2] !== 32'h33) begin
      n_fail++;
      $display("FAIL load_writes: n=%0d %h=%h %h=%h %h=%h required n=%0d 100=11 104=22 108=33",
               log_n - CLR_N, log_adr[CLR_N], log_dat[CLR_N], log_adr[CLR_N+1], log_dat[CLR_N+1],
               log_adr[CLR_N+2], log_dat[CLR_N+2], 3);
    end
  endtask

  task automatic test_overflow();
    int waited;
    logic stb_seen = 1'b0;
    apply_reset(1'b1);
    wait_ready("ovf", waited);
    for (int i = 0; i < 16; i++) send_word(32'(i + 1), 1'b0);
    send_word(32'h99, 1'b0);
    n_tests++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || wb_stb !== 1'b0) begin
      n_fail++; $display("FAIL ovf_err: err=%b cpu_rst=%b stb=%b required 1 1 0", err, cpu_rst, wb_stb);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      stb_seen = stb_seen | wb_stb;
    end
    n_tests++;
    if (stb_seen !== 1'b0 || log_n != CLR_N + 16 || words !== 32'd16) begin
      n_fail++;
      $display("FAIL ovf_count: stb_after=%b writes=%0d words=%0d required 0 16 16", stb_seen, log_n - CLR_N, words);
    end
    n_tests++;
    if (log_adr[CLR_N+15] !== 32'h13C || log_dat[CLR_N+15] !== 32'd16) begin
      n_fail++; $display("FAIL ovf_last: adr=%h dat=%h required 0000013c 00000010", log_adr[CLR_N+15], log_dat[CLR_N+15]);
    end
  endtask

  task automatic test_bus_err(input logic both);
    int waited;
    logic cyc_seen = 1'b0;
    err_en = 1'b1;
    both_mode = both;
    err_at = CLR_N + 1;
    apply_reset(1'b1);
    wait_ready("berr", waited);
    send_word(32'hA1, 1'b0);
    send_word(32'hA2, 1'b0);
    tick();
    n_tests++;
    if (err !== 1'b1 || words !== 32'd1 || cpu_rst !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL berr%0d_state: err=%b words=%0d cpu_rst=%b done=%b required 1 1 1 0", both, err, words, cpu_rst, done);
    end
    for (int i = 0; i < 4; i++) begin
      cyc_seen = cyc_seen | wb_cyc | wb_stb;
      tick();
    end
    n_tests++;
    if (cyc_seen !== 1'b0 || log_n != CLR_N + 1) begin
      n_fail++; $display("FAIL berr%0d_idle: bus_active=%b writes=%0d required 0 1", both, cyc_seen, log_n - CLR_N);
    end
    err_en = 1'b0;
    both_mode = 1'b0;
  endtask

  task automatic test_no_load();
    int n = 0;
    apply_reset(1'b0);
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != 5 + 2 * CLR_N) begin
      n_fail++; $display("FAIL noload_time: done after %0d cycles required %0d", n, 5 + 2 * CLR_N);
    end
    n_tests++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || words !== 32'd0 || log_n != CLR_N) begin
      n_fail++;
      $display("FAIL noload_state: done=%b cpu_rst=%b words=%0d writes=%0d required 1 0 0 %0d",
               done, cpu_rst, words, log_n, CLR_N);
    end
  endtask

  task automatic test_reset_midload();
    int waited;
    apply_reset(1'b1);
    wait_ready("mid", waited);
    send_word(32'h55, 1'b0);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({cpu_rst, done, err, wb_cyc, wb_stb, wb_we, load_ready} !== 7'b1000000 ||
        words !== 32'd0 || wb_adr !== 32'h100 || wb_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: ctl=%b words=%0d adr=%h dat=%h required 1000000 0 00000100 00000000",
               {cpu_rst, done, err, wb_cyc, wb_stb, wb_we, load_ready}, words, wb_adr, wb_dat);
    end
    tick();
    rst = 1'b0;
    wait_ready("mid2", waited);
    n_tests++;
    if (waited != 4 + 2 * CLR_N) begin
      n_fail++; $display("FAIL mid_restart: ready after %0d cycles required %0d", waited, 4 + 2 * CLR_N);
    end
    send_word(32'h77, 1'b1);
    tick();
    n_tests++;
    if (done !== 1'b1 || words !== 32'd1 || log_n != CLR_N + 1 ||
        log_adr[CLR_N] !== 32'h100 || log_dat[CLR_N] !== 32'h77) begin
      n_fail++;
      $display("FAIL mid_reload: done=%b words=%0d writes=%0d adr=%h dat=%h required 1 1 1 00000100 00000077",
               done, words, log_n - CLR_N, log_adr[CLR_N], log_dat[CLR_N]);
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_clear();
    test_load();
    test_overflow();
    test_bus_err(1'b0);
    test_bus_err(1'b1);
    test_no_load();
    test_reset_midload();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
